// File: rtl/column_deskewer.sv
// Realigns skewed per-lane results from the systolic array bottom edge
// into whole rows and buffers them in a small FIFO with a valid/ready output.
module column_deskewer #(
    parameter int LENGTH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LENGTH-1:0]            in_valid,
    input  logic [LENGTH*DATA_WIDTH-1:0] in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LENGTH*DATA_WIDTH-1:0] out,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [LENGTH*DATA_WIDTH-1:0] al_data;
    logic [LENGTH-1:0]            al_valid;

    // Lane i is delayed LENGTH-1-i cycles so all lanes of a row meet together.
    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        localparam int NS = LENGTH - 1 - i;
        if (NS == 0) begin : g_pass
            assign al_data[i*DATA_WIDTH +: DATA_WIDTH] = in[i*DATA_WIDTH +: DATA_WIDTH];
            assign al_valid[i] = in_valid[i];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] d_q [NS];
            logic [DATA_WIDTH-1:0] d_d [NS];
            logic                  v_q [NS];
            logic                  v_d [NS];

            always_comb begin
                d_d[0] = in[i*DATA_WIDTH +: DATA_WIDTH];
                v_d[0] = in_valid[i];
                for (int s = 1; s < NS; s++) begin
                    d_d[s] = d_q[s-1];
                    v_d[s] = v_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < NS; s++) begin
                        d_q[s] <= '0;
                        v_q[s] <= 1'b0;
                    end
                end else begin
                    for (int s = 0; s < NS; s++) begin
                        d_q[s] <= d_d[s];
                        v_q[s] <= v_d[s];
                    end
                end
            end

            assign al_data[i*DATA_WIDTH +: DATA_WIDTH] = d_q[NS-1];
            assign al_valid[i] = v_q[NS-1];
        end
    end

    logic [LENGTH*DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LENGTH*DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         overflow_q, overflow_d;
    logic                         misalign_q, misalign_d;

    logic all_v;
    logic any_v;
    logic pop;
    logic push;

    assign all_v = &al_valid;
    assign any_v = |al_valid;
    assign pop   = (count_q != '0) && out_ready;
    // A full FIFO still takes a row if the head leaves at the same edge.
    assign push  = all_v && ((count_q != FULL) || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (all_v & ~push);
        misalign_d = misalign_q | (any_v & ~all_v);
        if (push) begin
            mem_d[wr_ptr_q] = al_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            misalign_q <= misalign_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out       = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_column_deskewer.sv
// Scoreboard bench for column_deskewer: skewed directed rows in,
// aligned rows checked by an independent output monitor.
module tb_column_deskewer;

    localparam int L  = 4;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int W  = L * DW;

    logic            clk;
    logic            rst;
    logic [L-1:0]    in_valid;
    logic [W-1:0]    in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out;
    logic [$clog2(D):0] count;
    logic            overflow;
    logic            misalign;

    int checks = 0;
    int errors = 0;
    int max_count = 0;

    logic [W-1:0] exp_q [$];

    column_deskewer #(
        .LENGTH(L),
        .DATA_WIDTH(DW),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in(in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .count(count),
        .overflow(overflow),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output row must match the scoreboard head.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected got=%0h want=none", out);
            end else begin
                e = exp_q.pop_front();
                chk("pop_row", 128'(out), 128'(e));
            end
        end
        if (int'(count) > max_count) max_count = int'(count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        at_neg();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_out", 128'(out), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_misalign", 128'(misalign), 128'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in = '0;
        step();
        rst = 1'b0;
        check_reset_state();
    endtask

    // Rows k<n are driven skewed: lane i of row k in loop cycle k+i.
    task automatic send(input int n, input int base, input int bad_row,
                        input int bad_lane, input int nexp, input int rdy_at);
        logic [W-1:0] r;
        for (int k = 0; k < n; k++) begin
            if (k < nexp && k != bad_row) begin
                for (int i = 0; i < L; i++) r[i*DW +: DW] = 16'(base + 10*k + i);
                exp_q.push_back(r);
            end
        end
        for (int c = 0; c < n + L - 1; c++) begin
            if (rdy_at >= 0) out_ready = (c >= rdy_at);
            in_valid = '0;
            in = '0;
            for (int i = 0; i < L; i++) begin
                int k;
                k = c - i;
                if (k >= 0 && k < n && !(k == bad_row && i == bad_lane)) begin
                    in_valid[i] = 1'b1;
                    in[i*DW +: DW] = 16'(base + 10*k + i);
                end
            end
            step();
        end
        in_valid = '0;
        in = '0;
    endtask

    task automatic drain();
        for (int b = 0; b < 40; b++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        chk("drain_sb_empty", 128'(exp_q.size()), 128'(0));
        chk("drain_count", 128'(count), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_state();

        // single row, lanes 1..4
        out_ready = 1'b1;
        send(1, 1, -1, 0, 1, -1);
        at_neg();
        chk("single_valid_c4", 128'(out_valid), 128'(1));
        chk("single_out_c4", 128'(out), 128'(64'h0004_0003_0002_0001));
        step();
        at_neg();
        chk("single_valid_c5", 128'(out_valid), 128'(0));
        chk("single_count_c5", 128'(count), 128'(0));

        // streaming, back-to-back rows
        do_reset();
        max_count = 0;
        out_ready = 1'b1;
        send(4, 0, -1, 0, 4, -1);
        drain();
        chk("stream_max_count", 128'(max_count), 128'(1));
        chk("stream_overflow", 128'(overflow), 128'(0));
        chk("stream_misalign", 128'(misalign), 128'(0));

        // full then overflow on 5th row
        do_reset();
        out_ready = 1'b0;
        send(5, 100, -1, 0, 4, -1);
        at_neg();
        chk("ovf_count", 128'(count), 128'(4));
        chk("ovf_flag", 128'(overflow), 128'(1));
        out_ready = 1'b1;
        drain();
        chk("ovf_flag_sticky", 128'(overflow), 128'(1));

        // full with simultaneous pop when 5th row aligns
        do_reset();
        out_ready = 1'b0;
        send(5, 200, -1, 0, 5, 7);
        at_neg();
        chk("fullpop_count", 128'(count), 128'(4));
        chk("fullpop_overflow", 128'(overflow), 128'(0));
        drain();

        // missing lane 2 on one row
        do_reset();
        out_ready = 1'b1;
        send(1, 300, 0, 2, 0, -1);
        at_neg();
        chk("mis_flag", 128'(misalign), 128'(1));
        chk("mis_count", 128'(count), 128'(0));
        send(1, 400, -1, 0, 1, -1);
        at_neg();
        chk("mis_good_valid", 128'(out_valid), 128'(1));
        drain();
        chk("mis_sticky", 128'(misalign), 128'(1));

        // reset mid-operation
        do_reset();
        out_ready = 1'b0;
        send(2, 500, -1, 0, 0, -1);
        at_neg();
        chk("midrst_count_pre", 128'(count), 128'(2));
        in_valid = 4'b0001;
        in = 64'h0000_0000_0000_0AAA;
        step();
        in_valid = 4'b0010;
        in = 64'h0000_0000_0BBB_0000;
        step();
        in_valid = '0;
        in = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state();
        out_ready = 1'b1;
        send(1, 600, -1, 0, 1, -1);
        at_neg();
        chk("midrst_fresh_valid", 128'(out_valid), 128'(1));
        drain();
        chk("midrst_misalign", 128'(misalign), 128'(0));
        chk("midrst_overflow", 128'(overflow), 128'(0));

        repeat (3) step();
        chk("final_sb_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/column_deskewer.md
Name: column_deskewer

Overview:
- Output-side counterpart of the input column shifter. It collects skewed results from the bottom edge of the systolic array: lane i of a result row arrives i cycles after lane 0.
- Per-lane delay lines realign the lanes into whole rows. Rows are buffered in a small FIFO and handed downstream over a valid/ready handshake.
- Sits between the PE array outputs and the result writeback logic.

Parameters:
LENGTH, 4, number of lanes (array columns); must be >= 2
DATA_WIDTH, 16, bits per lane
DEPTH, 4, FIFO capacity in rows; power of two, >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  LENGTH  per-lane valid; bit i qualifies lane i
in  input  LENGTH*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH], skewed
out_valid  output  1  aligned row available at out
out_ready  input  1  downstream accepts row when out_valid && out_ready
out  output  LENGTH*DATA_WIDTH  aligned row, same lane packing as in
count  output  $clog2(DEPTH)+1  rows currently held in FIFO
overflow  output  1  sticky: a complete row was dropped because the FIFO was full
misalign  output  1  sticky: lanes of an aligned slot disagreed on valid

Behaviour:
- Reset (rst=1 at an edge):
  - clears all delay stages (data and valid), the FIFO pointers, count, overflow and misalign.
  - Next cycle: out_valid=0, count=0, out=0, overflow=0, misalign=0.
  - Reset mid-operation discards partially aligned rows; no row enters the FIFO from data presented before the reset edge.
- Alignment:
  - Lane i passes through LENGTH-1-i register stages, carrying both data and valid. Lane LENGTH-1 has zero stages.
  - A row whose lane 0 is presented in cycle t (lane i in cycle t+i) is aligned in cycle t+LENGTH-1.
- Slot check in the aligned cycle:
  - All aligned valids 1: row is a push candidate.
  - All aligned valids 0: no action.
  - Mixed valids: row discarded, misalign set (sticky until rst).
- Push:
  - Candidate is written at the edge ending cycle t+LENGTH-1 if count<DEPTH, or if count==DEPTH and a pop happens at that same edge.
  - Otherwise the row is dropped and overflow is set (sticky). FIFO contents are unchanged on a drop.
- Output:
  - out_valid=(count!=0). out shows the FIFO head, a registered value that is not combinational from in.
  - Pop occurs at an edge with out_valid && out_ready. out is held stable while out_valid && !out_ready.
- Latency: with the FIFO empty and out_ready=1, out_valid rises in cycle t+LENGTH. For LENGTH=4 that is 4 cycles after lane 0 was presented.
- Throughput: one row per cycle sustained, provided out_ready stays high.
- Count updates:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: unchanged.
  - Pointers wrap modulo DEPTH.
- Empty: out_ready while out_valid=0 has no effect, and count never underflows.
- Back-to-back rows with staggered lanes overlap in the delay lines without interference. Each lane stage only ever holds its own row's element.

Test Plan:
- Single row: LENGTH=4, DATA_WIDTH=16, DEPTH=4. Present lane0=1 @c0, lane1=2 @c1, lane2=3 @c2, lane3=4 @c3, out_ready=1. Required: out_valid=1 @c4 with out={4,3,2,1}, then out_valid=0 @c5, count back to 0.
- Streaming: 4 rows skewed back-to-back (row k lanes = 10k+i), out_ready=1. Required: rows pop in order on consecutive cycles c4..c7; count never exceeds 1; no flags set.
- Full/overflow: out_ready=0, push 5 rows. Required: count saturates at 4; overflow=1 after 5th aligned slot; out_ready=1 then yields rows 0..3 only, in order.
- Full with simultaneous pop: count=4, out_ready=1 on the cycle the 5th row aligns. Required: 5th row accepted, count stays 4, overflow=0.
- Misalign: lane2 valid missing for one row. Required: row not written, count unchanged, misalign=1 and stays 1. A subsequent good row is still delivered correctly.
- Reset mid-op: 2 rows in FIFO and 1 half-skewed in flight; pulse rst 1 cycle. Required: next cycle out_valid=0, count=0, flags 0. The in-flight row never appears, and a fresh row afterwards emerges after 4 cycles.
